// File: rtl/dmem_req_queue_if.sv
// Core/memory request and response bundle for dmem_req_queue.
interface dmem_req_queue_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid_i;
  logic              req_wen_i;
  logic              req_byte_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              req_ready_o;
  logic              mem_valid_o;
  logic              mem_wen_o;
  logic              mem_byte_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_yumi_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ryumi_o;
  logic              resp_valid_o;
  logic [DATA_W-1:0] resp_data_o;
  logic              resp_yumi_i;
  logic              idle_o;
  logic              err_o;

  modport slave (
    input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i,
    input  mem_yumi_i, mem_rvalid_i, mem_rdata_i, resp_yumi_i,
    output req_ready_o, mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    output mem_ryumi_o, resp_valid_o, resp_data_o, idle_o, err_o
  );

  modport master (
    output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i,
    output mem_yumi_i, mem_rvalid_i, mem_rdata_i, resp_yumi_i,
    input  req_ready_o, mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    input  mem_ryumi_o, resp_valid_o, resp_data_o, idle_o, err_o
  );
endinterface

// File: rtl/dmem_req_queue.sv
// In-order data-memory request queue with load-credit tracking and byte-lane response formatting.
// Optional DMEM_ERR_CHECK_EN: drop misaligned word requests / flag spurious read data on sticky err_o.
module dmem_req_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_LD = 4
) (
  input logic            clk,
  input logic            n_reset,
  dmem_req_queue_if.slave bus
);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned RQW   = PW + 1;
  localparam int unsigned LIW   = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;
  localparam int unsigned RCW   = LIW + 1;
  localparam int unsigned RD    = 2 ** LIW;
  localparam int unsigned LCW   = $clog2(MAX_LD) + 1;
  localparam int unsigned LANES = DATA_W / 8;

  typedef struct packed {
    logic              wen;
    logic              byte_op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic       byte_op;
    logic [1:0] off;
  } lane_t;

  req_t              rq_mem [DEPTH];
  logic [RQW-1:0]    rq_wp, rq_rp;
  lane_t             ln_mem [RD];
  logic [RCW-1:0]    ln_wp, ln_rp;
  logic [DATA_W-1:0] rs_mem [RD];
  logic [RCW-1:0]    rs_wp, rs_rp;
  logic [LCW-1:0]    ld_cnt;

  logic rq_empty_c, rq_full_c, push_c, push_wr_c, misaligned_c;
  logic mem_valid_c, pop_c, ld_pop_c, spurious_c, capture_c, rs_empty_c, consume_c;
  req_t                   head_c;
  lane_t                  lane_c;
  logic [LANES-1:0][7:0]  rs_lanes_c;
  logic [RCW-1:0]         rs_cnt_c;
  logic [DATA_W-1:0]      resp_c;

  // Request FIFO status and handshakes
  assign rq_empty_c  = (rq_wp == rq_rp);
  assign rq_full_c   = (rq_wp[PW] != rq_rp[PW]) && (rq_wp[PW-1:0] == rq_rp[PW-1:0]);
  assign head_c      = rq_mem[rq_rp[PW-1:0]];
  assign push_c      = bus.req_valid_i && !rq_full_c;
  assign push_wr_c   = push_c && !misaligned_c;
  assign mem_valid_c = !rq_empty_c && (head_c.wen || (ld_cnt < LCW'(MAX_LD)));
  assign pop_c       = mem_valid_c && bus.mem_yumi_i;
  assign ld_pop_c    = pop_c && !head_c.wen;

  // Read data is only accepted while some issued load still lacks its data
  assign rs_cnt_c    = rs_wp - rs_rp;
  assign spurious_c  = bus.mem_rvalid_i && (rs_cnt_c >= RCW'(ld_cnt));
  assign capture_c   = bus.mem_rvalid_i && !spurious_c;
  assign rs_empty_c  = (rs_wp == rs_rp);
  assign consume_c   = !rs_empty_c && bus.resp_yumi_i;

  assign lane_c      = ln_mem[ln_rp[LIW-1:0]];
  assign rs_lanes_c  = rs_mem[rs_rp[LIW-1:0]];

  always_comb begin
    resp_c = rs_lanes_c;
    if (lane_c.byte_op) resp_c = DATA_W'(rs_lanes_c[lane_c.off]);
  end

  assign bus.req_ready_o  = !rq_full_c;
  assign bus.mem_valid_o  = mem_valid_c;
  assign bus.mem_wen_o    = head_c.wen;
  assign bus.mem_byte_o   = head_c.byte_op;
  assign bus.mem_addr_o   = head_c.addr;
  assign bus.mem_wdata_o  = head_c.byte_op ? {LANES{head_c.wdata[7:0]}} : head_c.wdata;
  assign bus.mem_ryumi_o  = bus.mem_rvalid_i;
  assign bus.resp_valid_o = !rs_empty_c;
  assign bus.resp_data_o  = resp_c;
  assign bus.idle_o       = rq_empty_c && rs_empty_c && (ld_cnt == '0);

  // Pointers and load credit
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rq_wp  <= '0;
      rq_rp  <= '0;
      ln_wp  <= '0;
      ln_rp  <= '0;
      rs_wp  <= '0;
      rs_rp  <= '0;
      ld_cnt <= '0;
    end else begin
      if (push_wr_c) rq_wp <= rq_wp + RQW'(1);
      if (pop_c)     rq_rp <= rq_rp + RQW'(1);
      if (ld_pop_c)  ln_wp <= ln_wp + RCW'(1);
      if (capture_c) rs_wp <= rs_wp + RCW'(1);
      if (consume_c) begin
        ln_rp <= ln_rp + RCW'(1);
        rs_rp <= rs_rp + RCW'(1);
      end
      case ({ld_pop_c, consume_c})
        2'b10:   ld_cnt <= ld_cnt + LCW'(1);
        2'b01:   ld_cnt <= ld_cnt - LCW'(1);
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_wr_c) rq_mem[rq_wp[PW-1:0]] <= '{wen: bus.req_wen_i, byte_op: bus.req_byte_i,
                                               addr: bus.req_addr_i, wdata: bus.req_wdata_i};
    if (ld_pop_c)  ln_mem[ln_wp[LIW-1:0]] <= '{byte_op: head_c.byte_op, off: head_c.addr[1:0]};
    if (capture_c) rs_mem[rs_wp[LIW-1:0]] <= bus.mem_rdata_i;
  end

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;

  assign misaligned_c = !bus.req_byte_i && (bus.req_addr_i[1:0] != 2'b00);
  assign bus.err_o    = err_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) err_q <= 1'b0;
    else          err_q <= err_q | (push_c & misaligned_c) | spurious_c;
  end
`else
  assign misaligned_c = 1'b0;
  assign bus.err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_req_queue.sv
// Randomized bench for dmem_req_queue against a queue-based reference model, plus directed scenarios.
module tb_dmem_req_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAX_LD = 2;

  typedef struct {
    logic        wen;
    logic        byt;
    logic [11:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state
  mreq_t       rq[$];
  logic [2:0]  lane_q[$];
  logic [31:0] rsp_q[$];
  int          mem_pend = 0;
  logic        err_m = 1'b0;

  dmem_req_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LD(MAX_LD)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] ln);
    if (ln[2]) return (w >> (32'(ln[1:0]) * 8)) & 32'hFF;
    return w;
  endfunction

  function automatic logic exp_mem_valid();
    return (rq.size() > 0) && (rq[0].wen || lane_q.size() < int'(MAX_LD));
  endfunction

  // Model update: what the queue must hold after each clock edge
  always @(posedge clk or negedge n_reset) begin
    logic  ev, pushok, pop, spur, cons, bad, rv_mem;
    mreq_t h;
    if (!n_reset) begin
      rq.delete(); lane_q.delete(); rsp_q.delete();
      mem_pend = 0;
      err_m = 1'b0;
    end else begin
      ev     = exp_mem_valid();
      pushok = bus.req_valid_i && (rq.size() < int'(DEPTH));
      pop    = ev && bus.mem_yumi_i;
      spur   = bus.mem_rvalid_i && (rsp_q.size() >= lane_q.size());
      cons   = (rsp_q.size() > 0) && bus.resp_yumi_i;
      rv_mem = bus.mem_rvalid_i && (mem_pend > 0);
`ifdef DMEM_ERR_CHECK_EN
      bad = !bus.req_byte_i && (bus.req_addr_i[1:0] != 2'b00);
      if ((pushok && bad) || spur) err_m = 1'b1;
`else
      bad = 1'b0;
`endif
      if (rv_mem) mem_pend--;
      if (pop) begin
        h = rq.pop_front();
        if (!h.wen) begin
          lane_q.push_back({h.byt, h.addr[1:0]});
          mem_pend++;
        end
      end
      if (pushok && !bad) begin
        h.wen = bus.req_wen_i; h.byt = bus.req_byte_i;
        h.addr = bus.req_addr_i; h.wdata = bus.req_wdata_i;
        rq.push_back(h);
      end
      if (bus.mem_rvalid_i && !spur) rsp_q.push_back(bus.mem_rdata_i);
      if (cons) begin
        void'(rsp_q.pop_front());
        void'(lane_q.pop_front());
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic ev;
    ev = exp_mem_valid();
    chk("req_ready", 32'(bus.req_ready_o), 32'(rq.size() < int'(DEPTH)));
    chk("mem_valid", 32'(bus.mem_valid_o), 32'(ev));
    if (ev) begin
      chk("mem_wen",   32'(bus.mem_wen_o), 32'(rq[0].wen));
      chk("mem_byte",  32'(bus.mem_byte_o), 32'(rq[0].byt));
      chk("mem_addr",  32'(bus.mem_addr_o), 32'(rq[0].addr));
      if (rq[0].wen)
        chk("mem_wdata", bus.mem_wdata_o, rq[0].byt ? {4{rq[0].wdata[7:0]}} : rq[0].wdata);
    end
    chk("mem_ryumi", 32'(bus.mem_ryumi_o), 32'(bus.mem_rvalid_i));
    chk("resp_valid", 32'(bus.resp_valid_o), 32'(rsp_q.size() > 0));
    if (rsp_q.size() > 0) chk("resp_data", bus.resp_data_o, fmt(rsp_q[0], lane_q[0]));
    chk("idle", 32'(bus.idle_o),
        32'(rq.size() == 0 && rsp_q.size() == 0 && lane_q.size() == 0));
    chk("err", 32'(bus.err_o), 32'(err_m));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0; bus.req_wen_i = 1'b0; bus.req_byte_i = 1'b0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.mem_yumi_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    bus.resp_yumi_i = 1'b0;
  endtask

  task automatic req(input logic wen, input logic byt, input logic [11:0] a, input logic [31:0] d);
    bus.req_valid_i = 1'b1; bus.req_wen_i = wen; bus.req_byte_i = byt;
    bus.req_addr_i = a; bus.req_wdata_i = d;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mem_valid"}, 32'(bus.mem_valid_o), 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
    chk({tag, "_idle"}, 32'(bus.idle_o), 32'd1);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid_i = 1'($urandom);
      bus.req_wen_i   = 1'($urandom);
      bus.req_byte_i  = ($urandom % 4) == 0;
      bus.req_addr_i  = ($urandom % 8 == 0) ? 12'($urandom) : {10'($urandom), 2'b00};
      bus.req_wdata_i = $urandom;
      bus.mem_yumi_i  = ($urandom % 4) != 0;
      bus.resp_yumi_i = ($urandom % 3) != 0;
      bus.mem_rvalid_i = (mem_pend > 0) ? 1'($urandom) : (($urandom % 16) == 0);
      bus.mem_rdata_i = $urandom;
      step();
    end
  endtask

  task automatic drain();
    idle_inputs();
    bus.mem_yumi_i = 1'b1;
    bus.resp_yumi_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.mem_rvalid_i = (mem_pend > 0);
      bus.mem_rdata_i = $urandom;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    n_reset = 1'b0;
    step(); step();
    check_reset_state("por");
    n_reset = 1'b1;
    step();

    // Fill and drain; push while full and popping is refused
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, 12'(i * 4), $urandom);
      step();
    end
    chk("fill_ready_low", 32'(bus.req_ready_o), 32'd0);
    req(1'b1, 1'b0, 12'h010, 32'h0);
    step();
    chk("fill_head", 32'(bus.mem_addr_o), 32'h000);
    req(1'b1, 1'b0, 12'h020, 32'h0);
    bus.mem_yumi_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    chk("full_pop_ready", 32'(bus.req_ready_o), 32'd1);
    chk("drain_1", 32'(bus.mem_addr_o), 32'h004);
    step();
    chk("drain_2", 32'(bus.mem_addr_o), 32'h008);
    step();
    chk("drain_3", 32'(bus.mem_addr_o), 32'h00C);
    step();
    chk("drain_empty", 32'(bus.mem_valid_o), 32'd0);
    bus.mem_yumi_i = 1'b0;

    // Byte lanes
    req(1'b1, 1'b1, 12'h103, 32'h123456A5);
    step();
    bus.req_valid_i = 1'b0;
    chk("sb_wdata", bus.mem_wdata_o, 32'hA5A5A5A5);
    bus.mem_yumi_i = 1'b1;
    step();
    bus.mem_yumi_i = 1'b0;
    req(1'b0, 1'b1, 12'h102, 32'h0);
    step();
    bus.req_valid_i = 1'b0;
    bus.mem_yumi_i = 1'b1;
    step();
    bus.mem_yumi_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h11223344;
    step();
    bus.mem_rvalid_i = 1'b0;
    chk("lbu_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("lbu_data", bus.resp_data_o, 32'h00000022);
    bus.resp_yumi_i = 1'b1;
    step();
    bus.resp_yumi_i = 1'b0;
    chk("lbu_idle", 32'(bus.idle_o), 32'd1);

    // Load credit with MAX_LD = 2
    bus.mem_yumi_i = 1'b1;
    req(1'b0, 1'b0, 12'h040, 32'h0); step();
    req(1'b0, 1'b0, 12'h044, 32'h0); step();
    req(1'b0, 1'b0, 12'h048, 32'h0); step();
    bus.req_valid_i = 1'b0;
    chk("credit_hold", 32'(bus.mem_valid_o), 32'd0);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hAAAA0001; step();
    bus.mem_rdata_i = 32'hBBBB0002; step();
    bus.mem_rvalid_i = 1'b0;
    chk("credit_resp0", bus.resp_data_o, 32'hAAAA0001);
    step();
    chk("credit_still_held", 32'(bus.mem_valid_o), 32'd0);
    bus.resp_yumi_i = 1'b1;
    step();
    bus.resp_yumi_i = 1'b0;
    chk("credit_release", 32'(bus.mem_valid_o), 32'd1);
    chk("credit_release_addr", 32'(bus.mem_addr_o), 32'h048);
    chk("credit_resp1", bus.resp_data_o, 32'hBBBB0002);
    // Load pop and response consume in the same cycle leave the credit count unchanged
    req(1'b0, 1'b0, 12'h04C, 32'h0);
    bus.resp_yumi_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    bus.resp_yumi_i = 1'b0;
    chk("incdec_valid", 32'(bus.mem_valid_o), 32'd1);
    chk("incdec_addr", 32'(bus.mem_addr_o), 32'h04C);
    step();
    bus.mem_yumi_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1; step();
    bus.mem_rdata_i = 32'h2; step();
    bus.mem_rvalid_i = 1'b0;
    bus.resp_yumi_i = 1'b1; step(); step();
    bus.resp_yumi_i = 1'b0; step();
    chk("credit_idle", 32'(bus.idle_o), 32'd1);

    // Misaligned word load
    req(1'b0, 1'b0, 12'h002, 32'h0);
    step();
    bus.req_valid_i = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    chk("misal_valid", 32'(bus.mem_valid_o), 32'd0);
    chk("misal_err", 32'(bus.err_o), 32'd1);
`else
    chk("misal_valid", 32'(bus.mem_valid_o), 32'd1);
    chk("misal_addr", 32'(bus.mem_addr_o), 32'h002);
    chk("misal_err", 32'(bus.err_o), 32'd0);
`endif
    bus.mem_yumi_i = 1'b1; step();
    bus.mem_yumi_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF; step();
    bus.mem_rvalid_i = 1'b0;
    bus.resp_yumi_i = 1'b1; step();
    bus.resp_yumi_i = 1'b0;

    // Spurious read data is dropped
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h55555555; step();
    bus.mem_rvalid_i = 1'b0;
    chk("spurious_dropped", 32'(bus.resp_valid_o), 32'd0);

    // Random traffic, reset mid-operation, more random traffic
    rand_cycles(400);
    bus.req_valid_i = 1'b1;
    n_reset = 1'b0;
    step();
    check_reset_state("mid_reset");
    n_reset = 1'b1;
    idle_inputs();
    step();
    rand_cycles(400);
    drain();
    chk("final_idle", 32'(bus.idle_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
